// File: rtl/keccak_pkg.sv
// Shared constants and FSM encoding for the SHA3-256 sponge controller.
package keccak_pkg;
  localparam int NUM_ROUNDS          = 24;
  localparam int RATE_LANES_SHA3_256 = 17;
  localparam int LANE_W              = 64;
  localparam int STATE_W             = 25 * LANE_W;
  localparam logic [7:0] SHA3_DOMAIN_PAD = 8'h06;
  localparam logic [7:0] PAD_END_BYTE    = 8'h80;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ABSORB,
    ST_PERMUTE,
    ST_PADBLK,
    ST_FINAL,
    ST_OUT
  } sponge_fsm_t;
endpackage

// File: rtl/sponge_pad_xor.sv
// Lane byte masking and pad10*1 insertion for the lane currently being absorbed.
module sponge_pad_xor #(
  parameter int         RATE_LANES = keccak_pkg::RATE_LANES_SHA3_256,
  parameter logic [7:0] DOMAIN_PAD = keccak_pkg::SHA3_DOMAIN_PAD
) (
  input  logic [keccak_pkg::LANE_W-1:0] msg_data,
  input  logic [3:0]                    msg_bytes,
  input  logic                          msg_last,
  input  logic [4:0]                    lane_pos,
  output logic [keccak_pkg::LANE_W-1:0] lane_xor,
  output logic                          next_pad,
  output logic                          end_pad,
  output logic                          defer_pad
);
  logic [3:0] nbytes;
  logic       at_end;
  logic       full_last;

  always_comb begin
    nbytes = 4'd8;
    if (msg_last && (msg_bytes < 4'd8)) nbytes = msg_bytes;
    at_end    = (lane_pos == 5'(RATE_LANES - 1));
    full_last = msg_last && (nbytes == 4'd8);
    lane_xor  = '0;
    for (int k = 0; k < 8; k++) begin
      if (4'(k) < nbytes) lane_xor[8*k +: 8] = msg_data[8*k +: 8];
    end
    // A short last lane carries the domain byte right after its final data byte.
    if (msg_last && (nbytes < 4'd8)) lane_xor[{nbytes[2:0], 3'b000} +: 8] = DOMAIN_PAD;
    next_pad  = full_last && !at_end;
    defer_pad = full_last && at_end;
    end_pad   = msg_last && !defer_pad;
  end
endmodule

// File: rtl/keccak_sponge_ctrl.sv
// SHA3-256 sponge scheduler: absorbs 64-bit lanes, pads, drives an external round core.
//   state      | meaning
//   ST_IDLE    | waiting for start
//   ST_ABSORB  | accepting message lanes into the rate
//   ST_PERMUTE | one round per cycle through the external core
//   ST_PADBLK  | inject a pad-only block after a full final block
//   ST_FINAL   | capture digest from lanes 0..3
//   ST_OUT     | hold digest until digest_ready
module keccak_sponge_ctrl #(
  parameter int         RATE_LANES  = keccak_pkg::RATE_LANES_SHA3_256,
  parameter int         NUM_ROUNDS  = keccak_pkg::NUM_ROUNDS,
  parameter logic [7:0] DOMAIN_PAD  = keccak_pkg::SHA3_DOMAIN_PAD,
  parameter int         DIGEST_BITS = 256
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           start,
  input  logic                           msg_valid,
  output logic                           msg_ready,
  input  logic [keccak_pkg::LANE_W-1:0]  msg_data,
  input  logic                           msg_last,
  input  logic [3:0]                     msg_bytes,
  output logic [keccak_pkg::STATE_W-1:0] rnd_state,
  output logic [4:0]                     rnd_idx,
  input  logic [keccak_pkg::STATE_W-1:0] rnd_result,
  output logic [DIGEST_BITS-1:0]         digest,
  output logic                           digest_valid,
  input  logic                           digest_ready,
  output logic                           busy
);
  import keccak_pkg::*;

  localparam int END_BYTE_LSB = LANE_W * (RATE_LANES - 1) + 56;

  sponge_fsm_t        fsm;
  logic [STATE_W-1:0] state;
  logic [4:0]         lane_cnt;
  logic               final_flag;
  logic               pad_pending;
  logic [LANE_W-1:0]  lane_xor;
  logic               next_pad;
  logic               end_pad;
  logic               defer_pad;
  logic [STATE_W-1:0] absorb_xor;
  logic [STATE_W-1:0] padblk_xor;
  logic               accept;
  logic               last_lane;

  sponge_pad_xor #(
    .RATE_LANES (RATE_LANES),
    .DOMAIN_PAD (DOMAIN_PAD)
  ) u_pad (
    .msg_data  (msg_data),
    .msg_bytes (msg_bytes),
    .msg_last  (msg_last),
    .lane_pos  (lane_cnt),
    .lane_xor  (lane_xor),
    .next_pad  (next_pad),
    .end_pad   (end_pad),
    .defer_pad (defer_pad)
  );

  assign accept    = msg_valid && msg_ready;
  assign last_lane = (lane_cnt == 5'(RATE_LANES - 1));
  assign rnd_state = state;

  always_comb begin
    absorb_xor = '0;
    absorb_xor[LANE_W*lane_cnt +: LANE_W] = lane_xor;
    if (next_pad) absorb_xor[LANE_W*(lane_cnt+1) +: 8] = DOMAIN_PAD;
    // XOR rather than assign so 0x06 and 0x80 merge to 0x86 on the same byte.
    if (end_pad) absorb_xor[END_BYTE_LSB +: 8] = absorb_xor[END_BYTE_LSB +: 8] ^ PAD_END_BYTE;
  end

  always_comb begin
    padblk_xor = '0;
    padblk_xor[7:0] = DOMAIN_PAD;
    padblk_xor[END_BYTE_LSB +: 8] = PAD_END_BYTE;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm          <= ST_IDLE;
      state        <= '0;
      lane_cnt     <= '0;
      rnd_idx      <= '0;
      final_flag   <= 1'b0;
      pad_pending  <= 1'b0;
      msg_ready    <= 1'b0;
      digest       <= '0;
      digest_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      case (fsm)
        ST_IDLE: begin
          if (start) begin
            state       <= '0;
            lane_cnt    <= '0;
            final_flag  <= 1'b0;
            pad_pending <= 1'b0;
            msg_ready   <= 1'b1;
            busy        <= 1'b1;
            fsm         <= ST_ABSORB;
          end
        end
        ST_ABSORB: begin
          if (accept) begin
            state <= state ^ absorb_xor;
            if (msg_last) begin
              lane_cnt    <= '0;
              msg_ready   <= 1'b0;
              final_flag  <= !defer_pad;
              pad_pending <= defer_pad;
              fsm         <= ST_PERMUTE;
            end else if (last_lane) begin
              lane_cnt   <= '0;
              msg_ready  <= 1'b0;
              final_flag <= 1'b0;
              fsm        <= ST_PERMUTE;
            end else begin
              lane_cnt <= lane_cnt + 5'd1;
            end
          end
        end
        ST_PERMUTE: begin
          state <= rnd_result;
          if (rnd_idx == 5'(NUM_ROUNDS - 1)) begin
            rnd_idx <= '0;
            if (pad_pending) begin
              fsm <= ST_PADBLK;
            end else if (final_flag) begin
              fsm <= ST_FINAL;
            end else begin
              msg_ready <= 1'b1;
              fsm       <= ST_ABSORB;
            end
          end else begin
            rnd_idx <= rnd_idx + 5'd1;
          end
        end
        ST_PADBLK: begin
          state       <= state ^ padblk_xor;
          pad_pending <= 1'b0;
          final_flag  <= 1'b1;
          fsm         <= ST_PERMUTE;
        end
        ST_FINAL: begin
          digest       <= state[DIGEST_BITS-1:0];
          digest_valid <= 1'b1;
          fsm          <= ST_OUT;
        end
        ST_OUT: begin
          if (digest_ready) begin
            digest_valid <= 1'b0;
            busy         <= 1'b0;
            fsm          <= ST_IDLE;
          end
        end
        default: fsm <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: doc/keccak_sponge_ctrl.md
Name: keccak_sponge_ctrl

Overview:
- Sponge scheduler for SHA3-256: owns the 1600-bit Keccak state register and absorbs 64-bit message lanes into the rate.
- Applies SHA3 pad10*1 padding and iterates an external combinational Keccak-f round core for 24 rounds per block.
- Presents the 256-bit digest over a valid/ready handshake.
- Sits between the host message stream and the round datapath.

Parameters:
- RATE_LANES, 17, number of 64-bit lanes in the rate (1088 bits for SHA3-256).
- NUM_ROUNDS, 24, rounds per permutation.
- DOMAIN_PAD, 8'h06, domain-separation/pad-start byte.
- DIGEST_BITS, 256, digest width, taken from lanes 0..3.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  pulse in IDLE: clear state, begin a new message.
- msg_valid  in  1  lane valid.
- msg_ready  out  1  lane accepted when msg_valid&&msg_ready.
- msg_data  in  64  message lane, little-endian (byte k = bits [8k+7:8k]).
- msg_last  in  1  final lane of message.
- msg_bytes  in  4  valid bytes in the last lane, 0..8; ignored unless msg_last.
- rnd_state  out  1600  current state to round core.
- rnd_idx  out  5  round index to round core.
- rnd_result  in  1600  round core output, combinational from rnd_state/rnd_idx.
- digest  out  256  hash, digest[7:0] = first hash byte.
- digest_valid  out  1  digest available.
- digest_ready  in  1  digest consumed.
- busy  out  1  high in any state except IDLE.

Behaviour:
- Reset (reset=0, async): FSM=IDLE, state=0, lane_cnt=0, rnd_idx=0, msg_ready=0, digest_valid=0, digest=0, busy=0.
- Lane mapping: lane i occupies state[64i+63:64i].
- FSM states: IDLE, ABSORB, PERMUTE, PADBLK, FINAL, OUT.
- IDLE: start=1 -> state<=0, lane_cnt<=0, go ABSORB.
- ABSORB:
  - msg_ready=1. On a handshake, state lane[lane_cnt] ^= masked msg_data.
  - Bytes at or above msg_bytes are zeroed when msg_last.
  - Not last: lane_cnt==RATE_LANES-1 -> lane_cnt<=0, go PERMUTE (final_flag=0); else lane_cnt++.
  - Last with msg_bytes<8: pad is applied in the same cycle.
    - lane[lane_cnt] byte msg_bytes ^= DOMAIN_PAD.
    - lane[RATE_LANES-1] byte 7 ^= 8'h80 (yields 0x86 when both land on the same byte).
    - go PERMUTE, final_flag=1.
  - Last with msg_bytes==8:
    - lane_cnt<RATE_LANES-1 -> lane[lane_cnt+1] byte0 ^= DOMAIN_PAD and lane16 byte7 ^= 0x80, go PERMUTE, final_flag=1.
    - lane_cnt==RATE_LANES-1 -> go PERMUTE, final_flag=0, pad_pending=1.
- PERMUTE:
  - msg_ready=0. Each cycle state<=rnd_result, rnd_idx++.
  - After rnd_idx==NUM_ROUNDS-1: rnd_idx<=0. Exactly 24 cycles per permutation.
  - Exit: pad_pending -> PADBLK; final_flag -> FINAL; else ABSORB.
- PADBLK: one cycle. lane0 byte0 ^= DOMAIN_PAD, lane16 byte7 ^= 0x80, clear pad_pending, set final_flag, go PERMUTE.
- FINAL: one cycle. digest<=state[255:0], digest_valid<=1, go OUT.
- OUT:
  - digest and digest_valid are held stable until digest_ready.
  - On the handshake: digest_valid<=0, go IDLE. digest keeps its last value.
- rnd_state is the state register at all times. rnd_idx is 0 outside PERMUTE.
- start outside IDLE is ignored. msg_valid outside ABSORB is not accepted.
- Empty message: msg_last with msg_bytes=0 is legal. msg_data is ignored and padding starts at byte 0.
- msg_bytes>8 with msg_last: treated as 8.
- Reset asserted mid-PERMUTE or in OUT: immediate return to reset values. No partial digest is emitted.
- Throughput: full block = 17 accept cycles + 24 permute cycles.
- Latency from the final-block permutation end to digest_valid = 1 cycle (FINAL).

Decomposition:
- Shared package keccak_pkg: NUM_ROUNDS, RATE_LANES_SHA3_256, SHA3_DOMAIN_PAD, PAD_END_BYTE (8'h80), lane width 64, FSM state encoding.
- One natural sub-module: sponge_pad_xor, the combinational lane mask and pad-byte insertion. It takes msg_data, msg_bytes, msg_last and the lane position, and returns the XOR vector for the target lane and the lane16 pad bit.
- The round core stays external.

Test Plan:
- Empty message: start, one beat msg_last=1, msg_bytes=0 -> digest = a7ffc6f8bf1ed76651c14756a061d662f580ff4de43b49fa82d80a4b80f8434a (byte a7 in digest[7:0]), digest_valid 26 cycles after the accept.
- "abc": msg_data=64'h0000000000636261, msg_bytes=3, last -> digest 3a985da74fe225b2045c172d6bd390bd855f086e3e9d525b46bfe24511431532.
- 136-byte message (17 full lanes, last beat msg_bytes=8) -> PADBLK entered. Two permutations observed (48 PERMUTE cycles). Digest matches the software SHA3-256 model.
- 135-byte message (last beat msg_bytes=7 in lane 16) -> single pad byte 0x86 at lane16 byte7. One permutation. Digest matches the model.
- Backpressure: msg_valid toggles 1/0, digest_ready held 0 for 10 cycles -> digest and digest_valid stable throughout. msg_ready=0 in every PERMUTE cycle.
- Reset asserted at rnd_idx=12 -> all outputs at reset values asynchronously. A new "abc" run afterwards yields the correct digest.
